al_controller: RTL and testbench

- Keyboard-entry controller for the alarm clock.
- Collects BCD digit keystrokes from the keyboard interface into a 16-bit HH:MM buffer.
- Issues one-cycle load strobes for the alarm register or the time counter, and requests alarm or keyboard-buffer display.
- Abandons entry after a period of keyboard inactivity measured in one_second pulses.

---
 rtl/al_controller.sv | 148 ++++++++++++++
 tb/tb_al_controller.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/al_controller.sv
// Alarm-clock keyboard-entry controller.
// Collects BCD digit keys into an HH:MM buffer, issues one-cycle load strobes
// for the alarm register or the time counter, and abandons an entry or an
// alarm display after TIMEOUT_SECONDS one_second pulses without a key.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// IDLE (0)     | waiting for a first digit or 'S'
// ENTRY (1)    | collecting digits, keyboard buffer is displayed
// LOAD_ALARM(2)| one clk: alarm register loads the buffer
// LOAD_TIME (3)| one clk: time counter loads the buffer
// SHOW_ALARM(4)| display shows the stored alarm time
module al_controller #(
  parameter int unsigned TIMEOUT_SECONDS = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        one_second,
  input  logic [7:0]  key,
  output logic [15:0] out_key_buffer,
  output logic        load_alarm,
  output logic        show_alarm,
  output logic        load_new_time,
  output logic        out_show_keyboard,
  output logic [3:0]  debug_state_out,
  output logic [7:0]  debug_seconds_out
);

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_ENTRY      = 4'd1,
    S_LOAD_ALARM = 4'd2,
    S_LOAD_TIME  = 4'd3,
    S_SHOW_ALARM = 4'd4
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT_SECONDS);

  localparam logic [7:0] KEY_A   = 8'h41;
  localparam logic [7:0] KEY_T   = 8'h54;
  localparam logic [7:0] KEY_S   = 8'h53;
  localparam logic [7:0] KEY_ESC = 8'h1B;

  state_t      state_q, state_d;
  logic [15:0] buf_q, buf_d;
  logic [7:0]  seconds_q, seconds_d;

  logic       key_digit, key_a, key_t, key_s, key_esc, key_known;
  logic       buf_valid;
  logic       counting;
  logic [7:0] seconds_inc;
  logic       timeout;

  // Key decode, time validity and timeout detection
  always_comb begin
    key_digit = (key >= 8'h30) && (key <= 8'h39);
    key_a     = (key == KEY_A);
    key_t     = (key == KEY_T);
    key_s     = (key == KEY_S);
    key_esc   = (key == KEY_ESC);
    key_known = key_digit | key_a | key_t | key_s | key_esc;

    // H1 H0 : M1 M0, with hours capped at 23
    buf_valid = (buf_q[15:12] <= 4'd2) &&
                (buf_q[11:8]  <= 4'd9) &&
                ((buf_q[15:12] != 4'd2) || (buf_q[11:8] <= 4'd3)) &&
                (buf_q[7:4]   <= 4'd5) &&
                (buf_q[3:0]   <= 4'd9);

    counting    = (state_q == S_ENTRY) || (state_q == S_SHOW_ALARM);
    seconds_inc = (seconds_q == 8'hFF) ? 8'hFF : seconds_q + 8'd1;
    // A recognised key in the same clk as one_second wins, so no timeout then
    timeout     = counting && one_second && !key_known &&
                  (seconds_inc == TIMEOUT_CNT);
  end

  // Next-state, buffer and inactivity counter
  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    seconds_d = seconds_q;

    if (counting && one_second) seconds_d = seconds_inc;
    if (key_known)              seconds_d = 8'd0;

    case (state_q)
      S_IDLE: begin
        if (key_digit) begin
          buf_d   = {12'h000, key[3:0]};
          state_d = S_ENTRY;
        end else if (key_s) begin
          state_d = S_SHOW_ALARM;
        end
      end
      S_ENTRY: begin
        if (key_digit) begin
          buf_d = {buf_q[11:0], key[3:0]};
        end else if (key_a) begin
          state_d = buf_valid ? S_LOAD_ALARM : S_IDLE;
        end else if (key_t) begin
          state_d = buf_valid ? S_LOAD_TIME : S_IDLE;
        end else if (key_esc || timeout) begin
          state_d = S_IDLE;
        end
      end
      S_LOAD_ALARM, S_LOAD_TIME: begin
        state_d = S_IDLE;
      end
      S_SHOW_ALARM: begin
        if (key_digit) begin
          buf_d   = {12'h000, key[3:0]};
          state_d = S_ENTRY;
        end else if (key_s || key_esc || timeout) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Every arrival in IDLE starts the inactivity count afresh
    if (state_d == S_IDLE) seconds_d = 8'd0;
  end

  // State, buffer and counter registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      buf_q     <= 16'h0000;
      seconds_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      seconds_q <= seconds_d;
    end
  end

  // Moore outputs decoded from the registered state
  assign out_key_buffer    = buf_q;
  assign load_alarm        = (state_q == S_LOAD_ALARM);
  assign load_new_time     = (state_q == S_LOAD_TIME);
  assign show_alarm        = (state_q == S_SHOW_ALARM);
  assign out_show_keyboard = (state_q == S_ENTRY);
  assign debug_state_out   = state_q;
  assign debug_seconds_out = seconds_q;

endmodule

// File: tb/tb_al_controller.sv
// Directed self-checking bench for the alarm-clock keyboard controller.
module tb_al_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        one_second;
  logic [7:0]  key;
  logic [15:0] out_key_buffer;
  logic        load_alarm, show_alarm, load_new_time, out_show_keyboard;
  logic [3:0]  debug_state_out;
  logic [7:0]  debug_seconds_out;

  int checks = 0;
  int errors = 0;

  al_controller #(.TIMEOUT_SECONDS(10)) dut (
    .clk               (clk),
    .reset             (reset),
    .one_second        (one_second),
    .key               (key),
    .out_key_buffer    (out_key_buffer),
    .load_alarm        (load_alarm),
    .show_alarm        (show_alarm),
    .load_new_time     (load_new_time),
    .out_show_keyboard (out_show_keyboard),
    .debug_state_out   (debug_state_out),
    .debug_seconds_out (debug_seconds_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [7:0] k);
    key = k;
    tick();
    key = 8'h00;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset      = 1'b1;
    one_second = 1'b0;
    key        = 8'h00;
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Reset state
    check("rst_state", 16'(debug_state_out), 16'd0);
    check("rst_buf", out_key_buffer, 16'h0000);
    check("rst_outs", {12'd0, load_alarm, show_alarm, load_new_time, out_show_keyboard}, 16'd0);
    check("rst_sec", 16'(debug_seconds_out), 16'd0);

    // Alarm entry 12:30
    press(8'h31);
    check("e1_state", 16'(debug_state_out), 16'd1);
    check("e1_buf", out_key_buffer, 16'h0001);
    check("e1_kb", 16'(out_show_keyboard), 16'd1);
    tick();
    press(8'h32);
    tick();
    press(8'h33);
    press(8'h30);
    check("e1_buf4", out_key_buffer, 16'h1230);
    check("e1_kb4", 16'(out_show_keyboard), 16'd1);
    press(8'h41);
    check("e1_la_on", 16'(load_alarm), 16'd1);
    check("e1_la_state", 16'(debug_state_out), 16'd2);
    check("e1_la_kb", 16'(out_show_keyboard), 16'd0);
    press(8'h37);                       // ignored during the load clk
    check("e1_la_off", 16'(load_alarm), 16'd0);
    check("e1_idle", 16'(debug_state_out), 16'd0);
    check("e1_buf_kept", out_key_buffer, 16'h1230);
    tick();

    // Time entry 07:45
    press(8'h30);
    press(8'h37);
    press(8'h34);
    press(8'h35);
    check("e2_buf", out_key_buffer, 16'h0745);
    press(8'h54);
    check("e2_lt_on", 16'(load_new_time), 16'd1);
    check("e2_la_quiet", 16'(load_alarm), 16'd0);
    check("e2_buf_load", out_key_buffer, 16'h0745);
    tick();
    check("e2_lt_off", 16'(load_new_time), 16'd0);
    check("e2_idle", 16'(debug_state_out), 16'd0);

    // Invalid hour 24:00
    press(8'h32);
    press(8'h34);
    press(8'h30);
    press(8'h30);
    press(8'h41);
    check("e3_state", 16'(debug_state_out), 16'd0);
    check("e3_la", 16'(load_alarm), 16'd0);
    tick();
    check("e3_la2", 16'(load_alarm), 16'd0);

    // Boundary 23:59 is valid
    press(8'h32);
    press(8'h33);
    press(8'h35);
    press(8'h39);
    press(8'h54);
    check("e4_lt", 16'(load_new_time), 16'd1);
    tick();

    // Minutes tens 6 is invalid
    press(8'h31);
    press(8'h39);
    press(8'h36);
    press(8'h30);
    press(8'h54);
    check("e5_state", 16'(debug_state_out), 16'd0);
    check("e5_lt", 16'(load_new_time), 16'd0);

    // Inactivity timeout during entry
    press(8'h35);
    check("to_buf", out_key_buffer, 16'h0005);
    for (int i = 1; i <= 9; i++) begin
      one_second = 1'b1;
      tick();
      one_second = 1'b0;
      check($sformatf("to_sec%0d", i), 16'(debug_seconds_out), 16'(i));
      check($sformatf("to_st%0d", i), 16'(debug_state_out), 16'd1);
      if (i == 4) begin
        press(8'h20);                   // unknown code: counter must hold
        check("to_ign_sec", 16'(debug_seconds_out), 16'd4);
        check("to_ign_st", 16'(debug_state_out), 16'd1);
      end
    end
    one_second = 1'b1;
    tick();
    one_second = 1'b0;
    check("to_state", 16'(debug_state_out), 16'd0);
    check("to_kb", 16'(out_show_keyboard), 16'd0);
    check("to_sec", 16'(debug_seconds_out), 16'd0);
    check("to_strobes", {14'd0, load_alarm, load_new_time}, 16'd0);
    check("to_buf_kept", out_key_buffer, 16'h0005);

    // Show alarm toggling, then a digit starts a new entry
    press(8'h53);
    check("sa_on", 16'(show_alarm), 16'd1);
    check("sa_state", 16'(debug_state_out), 16'd4);
    tick();
    press(8'h53);
    check("sa_off", 16'(show_alarm), 16'd0);
    check("sa_idle", 16'(debug_state_out), 16'd0);
    press(8'h53);
    press(8'h39);
    check("sa_entry", 16'(debug_state_out), 16'd1);
    check("sa_buf", out_key_buffer, 16'h0009);
    check("sa_show_off", 16'(show_alarm), 16'd0);

    // Digit coincident with the one_second that would time out
    for (int i = 0; i < 9; i++) begin
      one_second = 1'b1;
      tick();
      one_second = 1'b0;
    end
    check("co_sec9", 16'(debug_seconds_out), 16'd9);
    one_second = 1'b1;
    press(8'h31);
    one_second = 1'b0;
    check("co_state", 16'(debug_state_out), 16'd1);
    check("co_sec", 16'(debug_seconds_out), 16'd0);
    press(8'h32);
    press(8'h33);
    press(8'h34);
    press(8'h35);
    check("co_buf", out_key_buffer, 16'h2345);

    // Escape leaves the buffer intact
    press(8'h1B);
    check("esc_state", 16'(debug_state_out), 16'd0);
    check("esc_buf", out_key_buffer, 16'h2345);

    // Reset during entry aborts without a strobe
    press(8'h31);
    reset = 1'b1;
    press(8'h41);
    reset = 1'b0;
    check("rm_state", 16'(debug_state_out), 16'd0);
    check("rm_la", 16'(load_alarm), 16'd0);
    check("rm_buf", out_key_buffer, 16'h0000);
    tick();
    check("rm_la2", 16'(load_alarm), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
